// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: shared types for the alu_iter execution unit.
//   opT    - 3-bit op codes (0-3 match the legacy 4-op ALU)
//   stateT - control FSM encoding
//   isShift() - true for the three shift ops
package alu_iter_pkg;

  typedef enum logic [2:0] {
    OP_SRA = 3'b000,
    OP_SRL = 3'b001,
    OP_SUB = 3'b010,
    OP_ADD = 3'b011,
    OP_SLL = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_SLT = 3'b111
  } opT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  function automatic logic isShift(input opT op);
    return op inside {OP_SRA, OP_SRL, OP_SLL};
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// alu_iter_if: request/response bundle of the alu_iter unit.
//   Request : in_valid/in_ready handshake carrying in_a, in_b, in_c (shift amount), op.
//   Response: out_valid/out_ready handshake carrying ans, zero, ovf.
//   master = issue side (drives requests), slave = the ALU.
interface alu_iter_if #(parameter int WIDTH = 32);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [SHW-1:0]   in_c;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, in_a, in_b, in_c, op, out_ready,
    input  in_ready, out_valid, ans, zero, ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, op, out_ready,
    output in_ready, out_valid, ans, zero, ovf
  );
endinterface

// File: rtl/alu_iter_core.sv
// alu_iter_core: single-cycle combinational ops (ADD/SUB/AND/OR/SLT) and
// signed overflow for ADD/SUB. Shift ops yield res=0 here; the top handles them.
//   a, b : operands
//   op   : operation code
//   res  : result, ovf : signed overflow (ADD/SUB only)
module alu_iter_core
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opT               op,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);
  localparam int M = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum  = a + b;
    diff = a - b;
    res  = '0;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        res = sum;
        ovf = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: handshaked multi-cycle ALU, 8 ops, registered ans/zero/ovf.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : request (in_valid/in_ready, in_a, in_b, in_c, op) and
//                  response (out_valid/out_ready, ans, zero, ovf)
// Shifts run one bit per cycle (latency C+1) unless ALU_ITER_BARREL_SHIFT_EN
// is defined, in which case a barrel shifter gives latency 1 for every op.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  alu_iter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  stateT            state, nextState;
  opT               opQ;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] ansQ;
  logic             zeroQ, ovfQ;

  opT               opIn;
  logic [WIDTH-1:0] coreRes, idleRes, stepRes;
  logic             coreOvf, idleOvf, goShift;
  logic             inReady, outValid;

  assign opIn = opT'(bus.op);

  alu_iter_core #(.WIDTH(WIDTH)) uCore (
    .a   (bus.in_a),
    .b   (bus.in_b),
    .op  (opIn),
    .res (coreRes),
    .ovf (coreOvf)
  );

  // One-bit step of the iterative shifter; SRA refills with the msb.
  always_comb begin
    case (opQ)
      OP_SRA:  stepRes = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_SRL:  stepRes = {1'b0, work[WIDTH-1:1]};
      default: stepRes = {work[WIDTH-2:0], 1'b0};
    endcase
  end

`ifdef ALU_ITER_BARREL_SHIFT_EN
  logic [WIDTH-1:0] barrelRes;
  always_comb begin
    case (opIn)
      OP_SRA:  barrelRes = $signed(bus.in_a) >>> bus.in_c;
      OP_SRL:  barrelRes = bus.in_a >> bus.in_c;
      default: barrelRes = bus.in_a << bus.in_c;
    endcase
  end
`endif

  // Result produced directly from IDLE; a zero-length shift is just A.
  always_comb begin
    idleRes = coreRes;
    idleOvf = coreOvf;
    goShift = 1'b0;
    if (isShift(opIn)) begin
      idleOvf = 1'b0;
`ifdef ALU_ITER_BARREL_SHIFT_EN
      idleRes = barrelRes;
`else
      idleRes = bus.in_a;
      goShift = (bus.in_c != '0);
`endif
    end
  end

  always_comb begin
    nextState = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (bus.in_valid) nextState = goShift ? SHIFT : DONE;
      end
      SHIFT: if (cnt == SHW'(1)) nextState = DONE;
      DONE: begin
        outValid = 1'b1;
        if (bus.out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      opQ   <= OP_SRA;
      work  <= '0;
      cnt   <= '0;
      ansQ  <= '0;
      zeroQ <= 1'b0;
      ovfQ  <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: if (bus.in_valid) begin
          opQ  <= opIn;
          work <= bus.in_a;
          cnt  <= bus.in_c;
          if (!goShift) begin
            ansQ  <= idleRes;
            zeroQ <= (idleRes == '0);
            ovfQ  <= idleOvf;
          end
        end
        SHIFT: begin
          work <= stepRes;
          cnt  <= cnt - SHW'(1);
          // Last step lands straight in the result register.
          if (cnt == SHW'(1)) begin
            ansQ  <= stepRes;
            zeroQ <= (stepRes == '0);
            ovfQ  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.ans       = ansQ;
  assign bus.zero      = zeroQ;
  assign bus.ovf       = ovfQ;
endmodule
